seq_detector_param: RTL
=======================

# seq_detector_param

Parametrised serial bit-pattern detector, the successor to the fixed 1011 Mealy sequence detector. It accepts one qualified bit per clock and compares the last PATTERN_W accepted bits against a pattern that is runtime-loadable. It raises a combinational (Mealy) match flag and a registered (Moore-style) match flag, and supports overlapping and non-overlapping match modes. It sits between a serial bit source and control logic that counts or reacts to frame markers.

## Interface
- PATTERN_W, 4: pattern length in bits; legal range 2..32.
- PATTERN_RST, 4'b1011: pattern value after reset, width PATTERN_W; bit 0 is the most recently received bit.
- CNT_W, 8: width of the match counter.

- clk_c  in  1  clock; all state updates on the rising edge.
- reset_r  in  1  synchronous, active-high reset.
- in_i  in  1  serial data bit.
- valid_i  in  1  in_i is accepted this cycle.
- overlap_i  in  1  1 = overlapping matches, 0 = restart after each match; sampled per accepted bit.
- load_i  in  1  load pattern_i into the pattern register.
- pattern_i  in  PATTERN_W  new pattern value.
- cnt_clr_i  in  1  clear the match counter.
- q_o  out  1  Mealy match flag: combinational in the same cycle as the completing bit.
- q_reg_o  out  1  q_o registered: one cycle later.
- match_cnt_o  out  CNT_W  saturating count of matches.

## Operation
- State:
  - pattern_r (PATTERN_W bits)
  - hist_r, the last PATTERN_W-1 accepted bits
  - fill_r, the count of valid history bits, 0..PATTERN_W-1, saturating
  - q_reg_o
  - cnt_r
- Candidate word: {hist_r, in_i}, where in_i becomes bit 0.
- q_o = valid_i & ~load_i & (fill_r == PATTERN_W-1) & (candidate == pattern_r).
- On an accepted bit (valid_i=1, load_i=0):
  - hist_r shifts in in_i.
  - fill_r increments and saturates at PATTERN_W-1.
  - If q_o=1 and overlap_i=0, fill_r is set to 0 instead. The history bits are kept but are ignored until refilled.
- When valid_i=0: hist_r and fill_r hold, and q_o=0.
- Pattern load (load_i=1):
  - pattern_r <= pattern_i, hist_r <= 0, fill_r <= 0.
  - Any in_i presented in the same cycle is discarded and q_o=0.
  - load_i has priority over valid_i.
- Match counter:
  - Increments on each cycle with q_o=1 and saturates at 2^CNT_W-1.
  - cnt_clr_i=1 sets it to 0. Clear wins over a simultaneous match, and that match is not counted.
  - Counter clear does not affect detection state.
- Reset (reset_r=1):
  - pattern_r=PATTERN_RST, hist_r=0, fill_r=0, q_reg_o=0, cnt_r=0.
  - q_o is forced to 0 during reset.
  - Reset has priority over load_i, valid_i and cnt_clr_i.
  - Reset mid-sequence discards all partial history. A full PATTERN_W accepted bits are needed before the first match.

## Timing
- Mealy latency: q_o is asserted in the same cycle as the completing bit.
- Registered latency: q_reg_o is asserted on the next rising edge and lasts exactly one cycle per match.
- match_cnt_o updates on the edge after the match cycle.
- Back-to-back matches:
  - Overlap mode: possible on consecutive accepted bits if the pattern allows it, for example an all-ones pattern.
  - Non-overlap mode: there are at least PATTERN_W accepted bits between matches.
- A new pattern takes effect for bits accepted from the cycle after load_i.
- No handshake back-pressure: the block accepts every valid bit.

## Configuration
- SEQDET_MATCH_CNT_EN defined:
  - the cnt_r counter and cnt_clr_i logic are built
  - match_cnt_o behaves as described above
- SEQDET_MATCH_CNT_EN undefined:
  - no counter flops are built
  - match_cnt_o is tied to 0 and cnt_clr_i is ignored
  - q_o and q_reg_o are unchanged

## Test plan
- Detection after reset: reset_r high for 1 cycle, then with default pattern 1011 feed valid bits 1,0,1,1 -> q_o=1 only on the 4th bit cycle; q_reg_o=1 on the following cycle; match_cnt_o=1.
- Overlap vs non-overlap: stream 1,0,1,1,0,1,1 with overlap_i=1 -> q_o on bits 4 and 7, count 2; repeat after reset with overlap_i=0 -> q_o on bit 4 only, count 1.
- Valid gaps: 1,0 then valid_i=0 for 5 cycles, then 1,1 -> q_o=0 during the gap and q_o=1 on the final bit.
- Runtime load: load pattern_i=4'b0110 mid-stream with valid_i=1 in the same cycle -> that bit is dropped, no match; then feed 0,1,1,0 -> q_o=1 on the 4th bit; feed 1,0,1,1 -> no match.
- Reset mid-sequence: feed 1,0,1, assert reset_r, then feed 1 -> no match; full 1,0,1,1 is needed afterwards; q_reg_o=0 and match_cnt_o=0 after reset.
- Counter behaviour (CNT_W=2, SEQDET_MATCH_CNT_EN defined): 5 matches -> match_cnt_o saturates at 3; cnt_clr_i asserted in a match cycle -> match_cnt_o=0. Rebuild with the macro undefined -> match_cnt_o stays 0.

Source files
------------

// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector with a runtime-loadable pattern, Mealy and registered match flags.
// Optional saturating match counter is built only when SEQDET_MATCH_CNT_EN is defined.
module seq_detector_param #(
  parameter int                     PATTERN_W   = 4,
  parameter logic [PATTERN_W-1:0]   PATTERN_RST = 'b1011,
  parameter int                     CNT_W       = 8
) (
  input  logic                  clk_c,
  input  logic                  reset_r,
  input  logic                  in_i,
  input  logic                  valid_i,
  input  logic                  overlap_i,
  input  logic                  load_i,
  input  logic [PATTERN_W-1:0]  pattern_i,
  input  logic                  cnt_clr_i,
  output logic                  q_o,
  output logic                  q_reg_o,
  output logic [CNT_W-1:0]      match_cnt_o
);

  localparam int                FILL_W    = $clog2(PATTERN_W);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PATTERN_W - 1);

  logic [PATTERN_W-1:0] pattern_q, pattern_d;
  logic [PATTERN_W-2:0] hist_q, hist_d;
  logic [FILL_W-1:0]    fill_q, fill_d;
  logic                 q_reg_q;
  logic [PATTERN_W-1:0] candidate;
  logic                 match;

  // The newest bit lands in bit 0, so the oldest history bit ends up as the MSB.
  assign candidate = {hist_q, in_i};
  assign match     = ~reset_r & valid_i & ~load_i & (fill_q == FILL_FULL) & (candidate == pattern_q);
  assign q_o       = match;
  assign q_reg_o   = q_reg_q;

  // NOTE: every signal written here gets its hold value first, so no path leaves it unassigned (no latch).
  always_comb begin
    pattern_d = pattern_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    if (load_i) begin
      pattern_d = pattern_i;
      hist_d    = '0;
      fill_d    = '0;
    end else if (valid_i) begin
      hist_d = candidate[PATTERN_W-2:0];
      if (match && !overlap_i) begin
        fill_d = '0;
      end else if (fill_q != FILL_FULL) begin
        fill_d = fill_q + FILL_W'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk_c) begin
    if (reset_r) begin
      pattern_q <= PATTERN_RST;
      hist_q    <= '0;
      fill_q    <= '0;
      q_reg_q   <= 1'b0;
    end else begin
      pattern_q <= pattern_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      q_reg_q   <= match;
    end
  end

`ifdef SEQDET_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Clear beats a coincident match; the count sticks at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr_i) begin
      cnt_d = '0;
    end else if (match && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_c) begin
    if (reset_r) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign match_cnt_o = cnt_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr_i;
  assign match_cnt_o    = '0;
`endif

endmodule
